// File: rtl/microsequencer.sv
// -----------------------------------------------------------------------------
// microsequencer
//   Next-address stage of a microcoded multicycle RISC-V control unit. It holds
//   the micro-program counter (uaddr) that indexes the microcode ROM. Each cycle
//   it chooses the next uaddr from the microword's sequencing field and the
//   instruction opcode. It also handles stalls, flags illegal opcodes and counts
//   retired instructions.
//
// Ports
//   clk        : in  1        rising-edge clock
//   reset_n    : in  1        synchronous active-low reset
//   seq_ctl    : in  2        00 go-fetch, 01 dispatch1, 10 dispatch2, 11 sequential
//   op         : in  7        instruction-register opcode
//   stall      : in  1        memory-not-ready; freezes all state
//   uaddr      : out UADDR_W  registered micro-address
//   instr_done : out 1        one-cycle retire pulse
//   illegal_op : out 1        one-cycle illegal-dispatch pulse
//   instret    : out CNT_W    retired-instruction count
//
// Optional feature (macro MICROSEQ_ILLEGAL_TRAP_EN)
//   An illegal dispatch parks uaddr at TRAP_ADDR. It stays there, ignoring all
//   inputs, until reset. Without the macro, an illegal dispatch returns to Fetch.
// -----------------------------------------------------------------------------
module microsequencer #(
  parameter int UADDR_W = 4,
  parameter int CNT_W   = 32
`ifdef MICROSEQ_ILLEGAL_TRAP_EN
  ,
  parameter logic [UADDR_W-1:0] TRAP_ADDR = 4'hF
`endif
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [1:0]         seq_ctl,
  input  logic [6:0]         op,
  input  logic               stall,
  output logic [UADDR_W-1:0] uaddr,
  output logic               instr_done,
  output logic               illegal_op,
  output logic [CNT_W-1:0]   instret
);

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_RTYP = 7'b0110011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;

  localparam logic [UADDR_W-1:0] UA_FETCH    = UADDR_W'(4'd0);
  localparam logic [UADDR_W-1:0] UA_MEMADR   = UADDR_W'(4'd2);
  localparam logic [UADDR_W-1:0] UA_MEMREAD  = UADDR_W'(4'd3);
  localparam logic [UADDR_W-1:0] UA_MEMWRITE = UADDR_W'(4'd5);
  localparam logic [UADDR_W-1:0] UA_EXECR    = UADDR_W'(4'd6);
  localparam logic [UADDR_W-1:0] UA_BEQ      = UADDR_W'(4'd8);

  logic [UADDR_W-1:0] r_uaddr;
  logic               r_instr_done;
  logic               r_illegal_op;
  logic [CNT_W-1:0]   r_instret;

  logic [UADDR_W-1:0] w_next_uaddr;
  logic               w_retire;
  logic               w_illegal;
  logic               w_trapped;

  // Next-address decode from the sequencing field and opcode
  always_comb begin
    w_next_uaddr = r_uaddr;
    w_retire     = 1'b0;
    w_illegal    = 1'b0;
    case (seq_ctl)
      2'b00: begin
        w_next_uaddr = UA_FETCH;
        // A go-fetch taken from Fetch itself is not the end of an instruction
        w_retire     = (r_uaddr != UA_FETCH);
      end
      2'b11: begin
        w_next_uaddr = r_uaddr + {{(UADDR_W-1){1'b0}}, 1'b1};
      end
      2'b01: begin
        case (op)
          OP_LW, OP_SW: w_next_uaddr = UA_MEMADR;
          OP_RTYP:      w_next_uaddr = UA_EXECR;
          OP_BEQ:       w_next_uaddr = UA_BEQ;
          default:      w_illegal    = 1'b1;
        endcase
      end
      2'b10: begin
        case (op)
          OP_LW:   w_next_uaddr = UA_MEMREAD;
          OP_SW:   w_next_uaddr = UA_MEMWRITE;
          default: w_illegal    = 1'b1;
        endcase
      end
      default: begin
        w_next_uaddr = UA_FETCH;
      end
    endcase
    if (w_illegal) begin
`ifdef MICROSEQ_ILLEGAL_TRAP_EN
      w_next_uaddr = TRAP_ADDR;
`else
      w_next_uaddr = UA_FETCH;
`endif
    end else begin
      w_next_uaddr = w_next_uaddr;
    end
  end

`ifdef MICROSEQ_ILLEGAL_TRAP_EN
  logic r_trapped;

  // Sticky trap flag, cleared only by reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_trapped <= 1'b0;
    end else if (!stall && w_illegal && !r_trapped) begin
      r_trapped <= 1'b1;
    end else begin
      r_trapped <= r_trapped;
    end
  end

  assign w_trapped = r_trapped;
`else
  assign w_trapped = 1'b0;
`endif

  // Micro-PC, retire counter and event pulses
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_uaddr      <= '0;
      r_instr_done <= 1'b0;
      r_illegal_op <= 1'b0;
      r_instret    <= '0;
    end else if (stall || w_trapped) begin
      // Hold everything; the pending transition is re-evaluated once released
      r_uaddr      <= r_uaddr;
      r_instr_done <= 1'b0;
      r_illegal_op <= 1'b0;
      r_instret    <= r_instret;
    end else begin
      r_uaddr      <= w_next_uaddr;
      r_instr_done <= w_retire;
      r_illegal_op <= w_illegal;
      if (w_retire) begin
        r_instret <= r_instret + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        r_instret <= r_instret;
      end
    end
  end

  assign uaddr      = r_uaddr;
  assign instr_done = r_instr_done;
  assign illegal_op = r_illegal_op;
  assign instret    = r_instret;

endmodule

// File: tb/tb_microsequencer.sv
// -----------------------------------------------------------------------------
// tb_microsequencer
//   Directed bench for microsequencer. A small microcode ROM table turns the
//   current uaddr into seq_ctl. The ROM can also be overridden to force a
//   sequencing value. Each step pushes the expected outputs for the next edge,
//   then pops them and compares after the edge. A second instance with a 3-bit
//   counter checks counter wrap.
// -----------------------------------------------------------------------------
module tb_microsequencer;

  typedef struct {
    logic [3:0]  ua;
    logic        done;
    logic        ill;
    logic [31:0] cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  seq_ctl = 2'b11;
  logic [6:0]  op = 7'b0000000;
  logic        stall = 1'b1;
  logic [3:0]  uaddr;
  logic        instr_done;
  logic        illegal_op;
  logic [31:0] instret;

  logic [3:0]  s_uaddr;
  logic        s_instr_done;
  logic        s_illegal_op;
  logic [2:0]  s_instret;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] BEQ = 7'b1100011;
  localparam logic [6:0] BAD = 7'b1111111;

  microsequencer #(.UADDR_W(4), .CNT_W(32)) u_dut (
    .clk(clk), .reset_n(reset_n), .seq_ctl(seq_ctl), .op(op), .stall(stall),
    .uaddr(uaddr), .instr_done(instr_done), .illegal_op(illegal_op), .instret(instret)
  );

  microsequencer #(.UADDR_W(4), .CNT_W(3)) u_dut_small (
    .clk(clk), .reset_n(reset_n), .seq_ctl(seq_ctl), .op(op), .stall(stall),
    .uaddr(s_uaddr), .instr_done(s_instr_done), .illegal_op(s_illegal_op),
    .instret(s_instret)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] rom(input logic [3:0] a);
    case (a)
      4'd0: return 2'b11;
      4'd1: return 2'b01;
      4'd2: return 2'b10;
      4'd3: return 2'b11;
      4'd6: return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // seq < 0 selects the ROM; otherwise seq forces seq_ctl
  task automatic cyc(input logic st, input int seq, input logic [3:0] eu,
                     input logic ed, input logic ei, input logic [31:0] ec);
    exp_t e;
    stall   = st;
    seq_ctl = (seq < 0) ? rom(uaddr) : seq[1:0];
    exp_q.push_back('{ua: eu, done: ed, ill: ei, cnt: ec});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk("uaddr", {28'd0, uaddr}, {28'd0, e.ua});
    chk("instr_done", {31'd0, instr_done}, {31'd0, e.done});
    chk("illegal_op", {31'd0, illegal_op}, {31'd0, e.ill});
    chk("instret", instret, e.cnt);
  endtask

  initial begin
    // Reset with stall and sequential requested
    reset_n = 1'b0;
    cyc(1'b1, 3, 4'd0, 1'b0, 1'b0, 32'd0);
    cyc(1'b1, 3, 4'd0, 1'b0, 1'b0, 32'd0);
    chk("small_instret_rst", {29'd0, s_instret}, 32'd0);
    reset_n = 1'b1;

    // lw: 0,1,2,3,4,0
    op = LW;
    cyc(1'b0, -1, 4'd1, 1'b0, 1'b0, 32'd0);
    cyc(1'b0, -1, 4'd2, 1'b0, 1'b0, 32'd0);
    cyc(1'b0, -1, 4'd3, 1'b0, 1'b0, 32'd0);
    cyc(1'b0, -1, 4'd4, 1'b0, 1'b0, 32'd0);
    cyc(1'b0, -1, 4'd0, 1'b1, 1'b0, 32'd1);

    // Mixed stream sw, R-type, beq (11 cycles)
    op = SW;
    cyc(1'b0, -1, 4'd1, 1'b0, 1'b0, 32'd1);
    cyc(1'b0, -1, 4'd2, 1'b0, 1'b0, 32'd1);
    cyc(1'b0, -1, 4'd5, 1'b0, 1'b0, 32'd1);
    cyc(1'b0, -1, 4'd0, 1'b1, 1'b0, 32'd2);
    op = RT;
    cyc(1'b0, -1, 4'd1, 1'b0, 1'b0, 32'd2);
    cyc(1'b0, -1, 4'd6, 1'b0, 1'b0, 32'd2);
    cyc(1'b0, -1, 4'd7, 1'b0, 1'b0, 32'd2);
    cyc(1'b0, -1, 4'd0, 1'b1, 1'b0, 32'd3);
    op = BEQ;
    cyc(1'b0, -1, 4'd1, 1'b0, 1'b0, 32'd3);
    cyc(1'b0, -1, 4'd8, 1'b0, 1'b0, 32'd3);
    cyc(1'b0, -1, 4'd0, 1'b1, 1'b0, 32'd4);

    // lw with 3 stall cycles at MemRead: 8 cycles total
    op = LW;
    cyc(1'b0, -1, 4'd1, 1'b0, 1'b0, 32'd4);
    cyc(1'b0, -1, 4'd2, 1'b0, 1'b0, 32'd4);
    cyc(1'b0, -1, 4'd3, 1'b0, 1'b0, 32'd4);
    cyc(1'b1, -1, 4'd3, 1'b0, 1'b0, 32'd4);
    cyc(1'b1, -1, 4'd3, 1'b0, 1'b0, 32'd4);
    cyc(1'b1, -1, 4'd3, 1'b0, 1'b0, 32'd4);
    cyc(1'b0, -1, 4'd4, 1'b0, 1'b0, 32'd4);
    // Stall on the go-fetch must not lose the retire
    cyc(1'b1, -1, 4'd4, 1'b0, 1'b0, 32'd4);
    cyc(1'b0, -1, 4'd0, 1'b1, 1'b0, 32'd5);

    // Forced sequential walk 0..15 then wrap to 0 with no retire
    for (int i = 1; i <= 15; i++) begin
      cyc(1'b0, 3, 4'(i), 1'b0, 1'b0, 32'd5);
    end
    cyc(1'b0, 3, 4'd0, 1'b0, 1'b0, 32'd5);
    // Go-fetch from Fetch is not a retire
    cyc(1'b0, 0, 4'd0, 1'b0, 1'b0, 32'd5);

    // Retire beq instructions until the 3-bit counter wraps
    op = BEQ;
    for (int k = 6; k <= 8; k++) begin
      cyc(1'b0, -1, 4'd1, 1'b0, 1'b0, 32'(k - 1));
      cyc(1'b0, -1, 4'd8, 1'b0, 1'b0, 32'(k - 1));
      cyc(1'b0, -1, 4'd0, 1'b1, 1'b0, 32'(k));
      if (k == 7) chk("small_instret_max", {29'd0, s_instret}, 32'd7);
    end
    chk("small_instret_wrap", {29'd0, s_instret}, 32'd0);

    // Illegal opcode at Decode
    op = BAD;
    cyc(1'b0, -1, 4'd1, 1'b0, 1'b0, 32'd8);
`ifdef MICROSEQ_ILLEGAL_TRAP_EN
    cyc(1'b0, -1, 4'hF, 1'b0, 1'b1, 32'd8);
    for (int j = 0; j < 10; j++) begin
      cyc(1'(j % 2), j % 4, 4'hF, 1'b0, 1'b0, 32'd8);
    end
    reset_n = 1'b0;
    cyc(1'b0, 3, 4'd0, 1'b0, 1'b0, 32'd0);
    reset_n = 1'b1;
    op = BEQ;
    cyc(1'b0, -1, 4'd1, 1'b0, 1'b0, 32'd0);
`else
    cyc(1'b0, -1, 4'd0, 1'b0, 1'b1, 32'd8);
    cyc(1'b0, -1, 4'd1, 1'b0, 1'b0, 32'd8);
    // Illegal at dispatch2 too
    op = RT;
    cyc(1'b0, 2, 4'd0, 1'b0, 1'b1, 32'd8);
    op = BEQ;
    cyc(1'b0, -1, 4'd1, 1'b0, 1'b0, 32'd8);
    cyc(1'b0, -1, 4'd8, 1'b0, 1'b0, 32'd8);
    cyc(1'b0, -1, 4'd0, 1'b1, 1'b0, 32'd9);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
